// File: rtl/alu_dr_injector.sv
// rtl/alu_dr_injector.sv - clocked dual-rail token injector feeding the self-timed ALU stage
//
// Buffers binary operand words in a small FIFO, encodes each one as a dual-rail
// codeword and runs the four-phase return-to-zero handshake against ack_in.
//
// Optional feature macro: ALU_DR_ACK_TIMEOUT_EN (ack watchdog driving err).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready operand word handshake; in_ready = !full
//   in_a, in_b        binary operands (W bits)
//   in_sub            1 = subtract, 0 = add
//   a_dr, b_dr        dual-rail operands (2W wires), bit i on [2i+1]=true, [2i]=false
//   sub_dr            dual-rail op select, [1]=true, [0]=false
//   ack_in            ack_out of the ALU stage (asynchronous)
//   busy              handshake in progress (state != SPACER)
//   level             FIFO occupancy
//   err               ack watchdog flag (0 unless ALU_DR_ACK_TIMEOUT_EN)

module alu_dr_injector #(
    parameter int W           = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    input  logic                     in_sub,
    output logic [2*W-1:0]           a_dr,
    output logic [2*W-1:0]           b_dr,
    output logic [1:0]               sub_dr,
    input  logic                     ack_in,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = 2 * W + 1;

    typedef enum logic [1:0] {
        SPACER = 2'd0,
        DATA   = 2'd1,
        RTZ    = 2'd2
    } state_t;

    state_t state, next_state;

    function automatic logic [2*W-1:0] encode(input logic [W-1:0] v);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // ack synchroniser
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // ---------------------------------------------------------------
    // input FIFO; pointers carry one extra wrap bit so that
    // wr_ptr - rd_ptr is the occupancy directly
    // ---------------------------------------------------------------
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, push, pop;
    logic [DW-1:0] head;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == LW'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_a, in_b, in_sub};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // handshake FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SPACER;
        end else begin
            state <= next_state;
        end
    end

    // pop decisions look at the registered level, so an entry written on
    // this edge is not visible until the next one (no fall-through)
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            SPACER: begin
                if (!ack_s && level != '0) begin
                    pop        = 1'b1;
                    next_state = DATA;
                end
            end
            DATA: begin
                if (ack_s) next_state = RTZ;
            end
            RTZ: begin
                if (!ack_s) begin
                    if (level != '0) begin
                        pop        = 1'b1;
                        next_state = DATA;
                    end else begin
                        next_state = SPACER;
                    end
                end
            end
            default: next_state = SPACER;
        endcase
    end

    assign busy = (state != SPACER);

    // rails are pure flops: loaded on a pop, cleared whenever we leave DATA.
    // A pop only happens from SPACER/RTZ where rails are already zero, so a
    // spacer always separates two codewords.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dr   <= '0;
            b_dr   <= '0;
            sub_dr <= '0;
        end else if (pop) begin
            a_dr   <= encode(head[DW-1:W+1]);
            b_dr   <= encode(head[W:1]);
            sub_dr <= {head[0], ~head[0]};
        end else if (next_state != DATA) begin
            a_dr   <= '0;
            b_dr   <= '0;
            sub_dr <= '0;
        end
    end

    // ---------------------------------------------------------------
    // ack watchdog
    // ---------------------------------------------------------------
`ifdef ALU_DR_ACK_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] wd_cnt;
    logic          err_q;

    // counter saturates at TIMEOUT; err is raised on the edge it gets there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (next_state != state) begin
                wd_cnt <= '0;
            end else if (state != SPACER && wd_cnt != CW'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + CW'(1);
                if (wd_cnt == CW'(TIMEOUT - 1)) err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
